// File: rtl/spart_mmio_slave_if.sv
// rtl/spart_mmio_slave_if.sv - cache-side memory bus between master and SPART MMIO slave
interface spart_mmio_slave_if;
  logic        mem_valid;
  logic        mem_rw;
  logic [27:0] mem_addr;
  logic [31:0] mem_data_wr;
  logic [31:0] mem_data_rd;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_rw, mem_addr, mem_data_wr,
    input  mem_data_rd, mem_ready
  );

  modport slave (
    input  mem_valid, mem_rw, mem_addr, mem_data_wr,
    output mem_data_rd, mem_ready
  );
endinterface

// File: rtl/spart_mmio_slave.sv
// rtl/spart_mmio_slave.sv - MMIO slave with DATA/STATUS registers and RX/TX byte FIFOs for SPART
module spart_mmio_slave #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          ACK_DELAY   = 0,
  parameter logic [27:0] DATA_ADDR   = 28'h8000000,
  parameter logic [27:0] STATUS_ADDR = 28'h8000001
) (
  input  logic                 clk,
  input  logic                 rst,
  spart_mmio_slave_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_load,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(ACK_DELAY + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_RELEASE} state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [27:0]   addr_q;
  logic          rw_q;
  logic [7:0]    wdata_q;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_ovf, tx_ovf;

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.mem_data_wr[31:8];

  logic is_data, is_status, access;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_pop, rx_push, rx_ovf_evt;
  logic tx_wr, tx_push, tx_ovf_evt, tx_pop, status_rd;
  logic [31:0] status_word;

  assign is_data    = (addr_q == DATA_ADDR);
  assign is_status  = (addr_q == STATUS_ADDR);
  assign access     = (state == ST_RESP);
  assign rx_full    = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty   = (rx_count == CW'(0));
  assign tx_full    = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty   = (tx_count == CW'(0));
  // A full RX still accepts a byte when the bus pops on the same edge
  assign rx_pop     = access && !rw_q && is_data && !rx_empty;
  assign rx_push    = rx_valid && (!rx_full || rx_pop);
  assign rx_ovf_evt = rx_valid && rx_full && !rx_pop;
  assign tx_wr      = access && rw_q && is_data;
  assign tx_push    = tx_wr && !tx_full;
  assign tx_ovf_evt = tx_wr && tx_full;
  assign tx_pop     = !tx_empty && !tx_busy && !tx_load;
  assign status_rd  = access && !rw_q && is_status;
  assign status_word = {20'b0, 4'(rx_count), 4'b0, tx_ovf, rx_ovf, !rx_empty, !tx_full};

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
    if (tx_push) tx_mem[tx_wptr] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      rw_q            <= 1'b0;
      wdata_q         <= '0;
      bus.mem_ready   <= 1'b0;
      bus.mem_data_rd <= '0;
      tx_load         <= 1'b0;
      tx_data         <= '0;
      rx_wptr         <= '0;
      rx_rptr         <= '0;
      tx_wptr         <= '0;
      tx_rptr         <= '0;
      rx_count        <= '0;
      tx_count        <= '0;
      rx_ovf          <= 1'b0;
      tx_ovf          <= 1'b0;
    end else begin
      tx_load <= tx_pop;
      if (tx_pop) tx_data <= tx_mem[tx_rptr];

      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);

      // A status read clears the sticky flags, but a same-edge event wins
      rx_ovf <= rx_ovf_evt || (rx_ovf && !status_rd);
      tx_ovf <= tx_ovf_evt || (tx_ovf && !status_rd);

      case (state)
        ST_IDLE: begin
          bus.mem_ready <= 1'b0;
          if (bus.mem_valid) begin
            addr_q  <= bus.mem_addr;
            rw_q    <= bus.mem_rw;
            wdata_q <= bus.mem_data_wr[7:0];
            cnt     <= DW'(ACK_DELAY);
            state   <= (ACK_DELAY > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (cnt == DW'(1)) begin
            cnt   <= '0;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - DW'(1);
          end
        end
        ST_RESP: begin
          bus.mem_ready <= 1'b1;
          state         <= ST_RELEASE;
          if (!rw_q) begin
            if (is_data)
              bus.mem_data_rd <= {24'b0, rx_pop ? rx_mem[rx_rptr] : 8'h00};
            else if (is_status)
              bus.mem_data_rd <= status_word;
            else
              bus.mem_data_rd <= '0;
          end
        end
        default: begin
          bus.mem_ready <= 1'b0;
          if (!bus.mem_valid) state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spart_mmio_slave.sv
// tb/tb_spart_mmio_slave.sv - directed self-checking bench for spart_mmio_slave
module tb_spart_mmio_slave;
  localparam logic [27:0] DATA_A   = 28'h8000000;
  localparam logic [27:0] STATUS_A = 28'h8000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spart_mmio_slave_if b0();
  spart_mmio_slave_if b1();

  logic [7:0] tx_data0, tx_data1, rx_data0;
  logic       tx_load0, tx_load1, tx_busy0, rx_valid0;

  spart_mmio_slave #(.FIFO_DEPTH(8), .ACK_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .tx_data(tx_data0), .tx_load(tx_load0), .tx_busy(tx_busy0),
    .rx_data(rx_data0), .rx_valid(rx_valid0)
  );

  spart_mmio_slave #(.FIFO_DEPTH(8), .ACK_DELAY(3)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .tx_data(tx_data1), .tx_load(tx_load1), .tx_busy(1'b0),
    .rx_data(8'h00), .rx_valid(1'b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_q[$];
  int   adj_err = 0;
  logic prev_load = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (tx_load0) begin
        tx_q.push_back(tx_data0);
        if (prev_load) adj_err++;
      end
      prev_load = tx_load0;
    end
  end

  task automatic bus_xfer(input bit sel, input bit rw, input logic [27:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    rdata = 'x;
    if (sel) begin
      b1.mem_valid = 1'b1; b1.mem_rw = rw; b1.mem_addr = addr; b1.mem_data_wr = wdata;
    end else begin
      b0.mem_valid = 1'b1; b0.mem_rw = rw; b0.mem_addr = addr; b0.mem_data_wr = wdata;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sel ? b1.mem_ready : b0.mem_ready) === 1'b1) begin
        lat = i;
        pulses = 1;
        rdata = sel ? b1.mem_data_rd : b0.mem_data_rd;
        break;
      end
    end
    if (lat > 0) begin
      repeat (3) begin
        @(posedge clk); #1;
        if ((sel ? b1.mem_ready : b0.mem_ready) === 1'b1) pulses++;
      end
    end
    if (sel) b1.mem_valid = 1'b0; else b0.mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid0 = 1'b1;
    rx_data0  = d;
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int lat, pulses;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b0.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", b0.mem_ready); end
    n_checks++; if (b0.mem_data_rd !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", b0.mem_data_rd); end
    n_checks++; if (tx_load0 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: got %b expected 0", tx_load0); end
    n_checks++; if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data0); end
    rst = 1'b0;
    @(posedge clk); #1;
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL idle_status: got %h expected 00000001", rd); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL idle_pulses: got %0d expected 1", pulses); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL idle_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_rx_read;
    logic [31:0] rd;
    int lat, pulses;
    rx_pulse(8'hA5);
    rx_pulse(8'h3C);
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000203) begin n_fail++; $display("FAIL rx_status2: got %h expected 00000203", rd); end
    bus_xfer(0, 0, DATA_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h000000A5) begin n_fail++; $display("FAIL rx_data0: got %h expected 000000A5", rd); end
    bus_xfer(0, 0, DATA_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h0000003C) begin n_fail++; $display("FAIL rx_data1: got %h expected 0000003C", rd); end
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL rx_status0: got %h expected 00000001", rd); end
    bus_xfer(0, 0, DATA_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000000) begin n_fail++; $display("FAIL rx_empty_read: got %h expected 00000000", rd); end
  endtask

  task automatic test_tx_single;
    logic [31:0] rd;
    int lat, pulses;
    tx_busy0 = 1'b0;
    tx_q.delete();
    bus_xfer(0, 1, DATA_A, 32'h12345678, rd, lat, pulses);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (tx_q.size() !== 1) begin n_fail++; $display("FAIL tx_single_count: got %0d expected 1", tx_q.size()); end
    if (tx_q.size() > 0) begin
      n_checks++; if (tx_q[0] !== 8'h78) begin n_fail++; $display("FAIL tx_single_byte: got %h expected 78", tx_q[0]); end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL tx_write_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] rd;
    int lat, pulses;
    tx_busy0 = 1'b1;
    tx_q.delete();
    for (int i = 0; i < 9; i++) bus_xfer(0, 1, DATA_A, 32'h10 + i, rd, lat, pulses);
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000008) begin n_fail++; $display("FAIL tx_ovf_status: got %h expected 00000008", rd); end
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000000) begin n_fail++; $display("FAIL tx_ovf_cleared: got %h expected 00000000", rd); end
    n_checks++; if (tx_q.size() !== 0) begin n_fail++; $display("FAIL tx_busy_hold: got %0d loads expected 0", tx_q.size()); end
    adj_err = 0;
    tx_busy0 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (tx_q.size() !== 8) begin n_fail++; $display("FAIL tx_drain_count: got %0d expected 8", tx_q.size()); end
    for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
      n_checks++;
      if (tx_q[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL tx_drain_byte%0d: got %h expected %h", i, tx_q[i], 8'(8'h10 + i)); end
    end
    n_checks++; if (adj_err !== 0) begin n_fail++; $display("FAIL tx_load_adjacent: got %0d expected 0", adj_err); end
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL tx_after_drain: got %h expected 00000001", rd); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] rd;
    int lat, pulses;
    rx_valid0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data0 = 8'(8'h50 + i);
      @(posedge clk); #1;
    end
    rx_valid0 = 1'b0;
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000807) begin n_fail++; $display("FAIL rx_ovf_status: got %h expected 00000807", rd); end
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000803) begin n_fail++; $display("FAIL rx_ovf_cleared: got %h expected 00000803", rd); end
    // Push lands on the same edge as the DATA read's access edge
    b0.mem_valid = 1'b1; b0.mem_rw = 1'b0; b0.mem_addr = DATA_A;
    @(posedge clk); #1;
    rx_valid0 = 1'b1; rx_data0 = 8'h99;
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
    n_checks++; if (b0.mem_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b expected 1", b0.mem_ready); end
    n_checks++; if (b0.mem_data_rd !== 32'h00000050) begin n_fail++; $display("FAIL full_pushpop_data: got %h expected 00000050", b0.mem_data_rd); end
    @(posedge clk); #1;
    b0.mem_valid = 1'b0;
    @(posedge clk); #1;
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000803) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 00000803", rd); end
    for (int i = 0; i < 8; i++) begin
      bus_xfer(0, 0, DATA_A, 32'h0, rd, lat, pulses);
      n_checks++;
      if (rd !== ((i < 7) ? 32'h51 + i : 32'h99)) begin
        n_fail++; $display("FAIL rx_drain%0d: got %h expected %h", i, rd, (i < 7) ? 32'h51 + i : 32'h99);
      end
    end
  endtask

  task automatic test_bad_addr;
    logic [31:0] rd;
    int lat, pulses;
    bus_xfer(0, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL pre_bad_status: got %h expected 00000001", rd); end
    bus_xfer(0, 0, 28'h0000010, 32'h0, rd, lat, pulses);
    n_checks++; if (rd !== 32'h00000000) begin n_fail++; $display("FAIL bad_addr_read: got %h expected 00000000", rd); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL bad_addr_pulses: got %0d expected 1", pulses); end
    tx_q.delete();
    bus_xfer(0, 1, 28'h0000010, 32'hEE, rd, lat, pulses);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL bad_write_pulses: got %0d expected 1", pulses); end
    bus_xfer(0, 1, STATUS_A, 32'hFF, rd, lat, pulses);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL status_write_pulses: got %0d expected 1", pulses); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (tx_q.size() !== 0) begin n_fail++; $display("FAIL ignored_write_tx: got %0d expected 0", tx_q.size()); end
  endtask

  task automatic test_ack_delay;
    logic [31:0] rd;
    int lat, pulses;
    bus_xfer(1, 0, STATUS_A, 32'h0, rd, lat, pulses);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ack_delay_latency: got %0d expected 5", lat); end
    n_checks++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL ack_delay_data: got %h expected 00000001", rd); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ack_delay_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_reset_in_wait;
    int seen = 0;
    b1.mem_valid = 1'b1; b1.mem_rw = 1'b0; b1.mem_addr = STATUS_A;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b1.mem_valid = 1'b0;
    n_checks++; if (b1.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready: got %b expected 0", b1.mem_ready); end
    n_checks++; if (b1.mem_data_rd !== 32'h0) begin n_fail++; $display("FAIL rst_wait_rdata: got %h expected 0", b1.mem_data_rd); end
    n_checks++; if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data0); end
    n_checks++; if (tx_load0 !== 1'b0) begin n_fail++; $display("FAIL rst_tx_load: got %b expected 0", tx_load0); end
    repeat (8) begin
      @(posedge clk); #1;
      if (b1.mem_ready === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_wait_no_ready: got %0d pulses expected 0", seen); end
  endtask

  initial begin
    b0.mem_valid = 1'b0; b0.mem_rw = 1'b0; b0.mem_addr = '0; b0.mem_data_wr = '0;
    b1.mem_valid = 1'b0; b1.mem_rw = 1'b0; b1.mem_addr = '0; b1.mem_data_wr = '0;
    tx_busy0 = 1'b0; rx_valid0 = 1'b0; rx_data0 = '0;
    test_reset();
    test_rx_read();
    test_tx_single();
    test_tx_overflow();
    test_rx_overflow();
    test_bad_addr();
    test_ack_delay();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spart_mmio_slave.md
Name: spart_mmio_slave

Overview:
- Memory-mapped bus slave between the cache-side bus master and the SPART UART core.
- Decodes two word addresses: a DATA register and a STATUS register.
- Buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO.
- Answers each bus request with a one-cycle mem_ready pulse, then waits for the master to drop mem_valid before it accepts another request.

Parameters:
- FIFO_DEPTH, 8: entries per FIFO. Power of two, range 2..8.
- ACK_DELAY, 0: extra wait cycles between accepting a request and the mem_ready pulse.
- DATA_ADDR, 28'h8000000: data register address.
- STATUS_ADDR, 28'h8000001: status register address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_valid  in  1  request valid, held by master until mem_ready is seen
- mem_rw  in  1  1 = write, 0 = read
- mem_addr  in  28  request address
- mem_data_wr  in  32  write data; only [7:0] is used
- mem_data_rd  out  32  read data, valid while mem_ready = 1
- mem_ready  out  1  one-cycle response pulse
- tx_data  out  8  byte to SPART transmitter
- tx_load  out  1  one-cycle load strobe to transmitter
- tx_busy  in  1  transmitter busy
- rx_data  in  8  byte from SPART receiver
- rx_valid  in  1  one-cycle received-byte strobe

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: mem_ready = 0, mem_data_rd = 0, tx_load = 0, tx_data = 0.
  - Both FIFOs empty, sticky flags 0, FSM in IDLE, delay counter 0.
  - Reset mid-transaction aborts it: no mem_ready is issued, FIFO contents are lost.
- Bus FSM states: IDLE, WAIT, RESP, RELEASE.
  - IDLE: on mem_valid = 1, latch addr/rw/wdata. Go to WAIT if ACK_DELAY > 0, else RESP. Load counter with ACK_DELAY.
  - WAIT: decrement counter; at 1, go to RESP.
  - RESP is the response edge: the edge entering RESP performs the access and registers mem_ready = 1 and mem_data_rd. mem_ready is high for exactly one cycle. Next state is RELEASE.
  - RELEASE: mem_ready = 0. Stay until mem_valid = 0, then IDLE. A request held high is never serviced twice.
  - Latency with ACK_DELAY = 0: request sampled at edge N, mem_ready high in the cycle after edge N+1.
- Accesses, all performed on the response edge:
  - Read DATA, RX non-empty: mem_data_rd = {24'b0, rx_head}; pop RX.
  - Read DATA, RX empty: mem_data_rd = 0; no pop.
  - Read STATUS:
    - [0] TX not full
    - [1] RX not empty
    - [2] rx_overflow (sticky)
    - [3] tx_overflow (sticky)
    - [11:8] RX count
    - all other bits 0
    - Sticky bits clear after capture. An overflow event on the same edge leaves its bit set.
  - Write DATA, TX not full: push mem_data_wr[7:0].
  - Write DATA, TX full: drop the byte, set tx_overflow.
  - Write STATUS: ignored, mem_ready still pulses.
  - Any other address: read returns 0, write is ignored, mem_ready still pulses (no hang). Decode compares all 28 bits.
  - mem_data_rd holds its last value when mem_ready = 0; it does not return to 0.
- RX path:
  - rx_valid = 1 pushes rx_data.
  - If RX is full and no pop occurs on that edge, the byte is dropped and rx_overflow is set.
  - Push and pop on the same edge when full: both succeed, no overflow, count unchanged.
  - Push into an empty FIFO on the same edge as a DATA read: the read sees empty (returns 0); the pushed byte remains.
- TX drain:
  - When TX is non-empty, tx_busy = 0, and tx_load was 0 in the previous cycle: assert tx_load for one cycle, drive tx_data = TX head, pop.
  - tx_load is never high on two consecutive cycles.
  - A bus push and a drain pop on the same edge are both honoured.
- FIFOs: circular, pointer width log2(FIFO_DEPTH). Pointers wrap modulo depth. Count register is 0..FIFO_DEPTH.

Test Plan:
- Reset, then read STATUS with idle SPART -> mem_data_rd = 32'h00000001, exactly one mem_ready pulse, RELEASE held until valid drops.
- Pulse rx_valid with 8'hA5, then 8'h3C; read STATUS, then DATA twice -> STATUS = 32'h00000203; DATA reads return 32'h000000A5, then 32'h0000003C; STATUS then = 32'h00000001.
- With tx_busy = 0, write DATA 32'h12345678 -> tx_load pulses once with tx_data = 8'h78; TX count returns to 0.
- Hold tx_busy = 1; issue 9 writes with FIFO_DEPTH = 8 -> STATUS = 32'h00000008, bit0 = 0, bit3 = 1. A second STATUS read clears bit3. Release tx_busy -> 8 bytes drain in order, tx_load never high on adjacent cycles.
- Push 9 RX bytes -> rx_overflow set, RX count = 8. Full push coincident with a DATA read -> no overflow, count stays 8.
- Read address 28'h0000010 -> returns 0 with mem_ready. With ACK_DELAY = 3, mem_ready arrives 3 cycles later. rst asserted in WAIT -> no mem_ready, all outputs at reset values.
